reg_write_bank: RTL and testbench
=================================

# reg_write_bank

Write side of the 32×32-bit register file. It accepts one write request per cycle through a valid/ready handshake and decodes the 5-bit address to a one-hot enable. It holds the 32 registers and presents all of them as a flat bus to the read-side 32:1 selectors. It also runs a multi-cycle bulk-clear sequence that stalls writes until it finishes; register 0 always reads as zero.

## Interface
- DATA_W, default 32: register width.
- ADDR_W, default 5: address width.
- NREG, default 32: register count; equals 2^ADDR_W.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- wr_valid  in  1  write request present.
- wr_ready  out  1  block can accept a write this cycle.
- wr_addr  in  ADDR_W  target register index.
- wr_data  in  DATA_W  write data.
- clr_start  in  1  request a bulk clear of registers 1..31.
- clr_busy  out  1  bulk clear in progress.
- wr_done  out  1  one-cycle pulse, registered, marking a completed write.
- wr_en_onehot  out  NREG  registered one-hot copy of the last committed write enable; all zero when wr_done is low.
- regs_flat  out  NREG*DATA_W  register k occupies bits [k*DATA_W +: DATA_W].

## Operation
- FSM has two states.
  - IDLE: wr_ready = 1, clr_busy = 0.
  - CLEAR: wr_ready = 0, clr_busy = 1.
- Write accept rule: a write is accepted when wr_valid && wr_ready at a rising edge. At that edge reg[wr_addr] <= wr_data.
- Address 0: the request is still accepted and wr_done still pulses. reg[0] stays 0, and wr_en_onehot[0] is set for that pulse.
- Transition IDLE→CLEAR: clr_start high at an edge in IDLE. The clear counter loads 1.
- CLEAR behaviour: at each edge reg[cnt] <= 0 and cnt increments.
- Transition CLEAR→IDLE: the edge that clears reg[31] returns the FSM to IDLE.
- clr_start in CLEAR: ignored; it does not restart the count.
- Simultaneous wr_valid and clr_start in IDLE: the write commits at that edge and the clear also starts. The clear later zeroes the written register, unless the target is 0.
- wr_valid in CLEAR: not accepted. The requester holds wr_addr and wr_data until wr_ready returns.
- Reset, including mid-clear:
  - all registers = 0
  - FSM = IDLE, counter = 1
  - wr_done = 0, wr_en_onehot = 0
  - wr_ready = 1 in the first cycle after the reset edge.
- Reset output values: wr_ready = 1, clr_busy = 0, wr_done = 0, wr_en_onehot = 0, regs_flat = 0.

## Timing
- Write latency: data accepted at edge t is visible on regs_flat in the cycle after edge t. wr_done and wr_en_onehot are asserted during that same cycle.
- Throughput: one write per cycle in IDLE; back-to-back writes need no bubble.
- Same-address writes on consecutive edges: the last one wins.
- wr_ready and clr_busy are decoded from the state register only; there is no combinational path from any input.
- Clear timing, with clr_start sampled at edge t:
  - clr_busy is high from cycle t+1 through t+31 (31 cycles).
  - reg[k] is zero after edge t+k.
  - wr_ready is high again after edge t+31.
- Counter width: ADDR_W. The counter never wraps to 0 while in CLEAR.

## Structure
- Shared package holds:
  - the DATA_W, ADDR_W and NREG constants;
  - the state encoding (IDLE = 1'b0, CLEAR = 1'b1).
- Sub-module decoder_5_32:
  - combinational address-to-one-hot decoder with an enable input;
  - it is the write-side counterpart of the read-side selector tree.
- The top level instantiates it once, on wr_addr gated by the accept condition.
- The 32 registers and the clear FSM live in the top level.

## Test plan
- Reset, then a write with wr_addr = 5 and wr_data = 32'hDEADBEEF → next cycle:
  - regs_flat slot 5 = DEADBEEF;
  - wr_done = 1;
  - wr_en_onehot = 32'h00000020;
  - all other slots = 0.
- Write to address 0 with 32'hFFFFFFFF → wr_done pulses, wr_en_onehot = 32'h1, slot 0 stays 0.
- Fill all 31 writable registers with index×3, then assert clr_start → checks:
  - clr_busy is high for exactly 31 cycles;
  - reg[k] reads zero starting the cycle after edge t+k;
  - wr_ready returns after edge t+31.
- Assert wr_valid (addr 7, data 32'h12345678) during CLEAR → not accepted until wr_ready is high again; then the write commits and reads back 32'h12345678.
- Same edge, wr_valid (addr 31, data 32'hA5A5A5A5) and clr_start → slot 31 = A5A5A5A5 after the first edge, then 0 after edge t+31.
- Assert reset at clear count 10 → all slots 0, state IDLE, and wr_ready = 1 in the first cycle after the reset edge. A following write to address 3 commits normally.

Source files
------------

// File: rtl/reg_write_bank_pkg.sv
// reg_write_bank_pkg
//   Shared constants and the clear-FSM state encoding for the register-file
//   write side.
//   Contents:
//     DATA_W  : register width
//     ADDR_W  : register index width
//     NREG    : register count (2**ADDR_W)
//     state_t : IDLE accepts writes, CLEAR runs the bulk clear
package reg_write_bank_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_write_bank_decoder.sv
// decoder_5_32
//   Combinational address-to-one-hot decoder with enable. This is the
//   write-side counterpart of the read-side 32:1 selector tree.
//   Ports:
//     en     in  1       all outputs zero when low
//     addr   in  ADDR_W  index to decode
//     onehot out NREG    bit addr set when en is high
module decoder_5_32 #(
  parameter int ADDR_W = reg_write_bank_pkg::ADDR_W,
  parameter int NREG   = reg_write_bank_pkg::NREG
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_bank.sv
// reg_write_bank
//   Write side of the register file: valid/ready write port, one-hot write
//   enable, the register storage itself and a bulk-clear sequencer that
//   zeroes registers 1..NREG-1, one per cycle, while stalling writes.
//   Register 0 is hard-wired to zero.
//   Ports:
//     clock        in  1            rising-edge clock
//     reset        in  1            synchronous active-high reset
//     wr_valid     in  1            write request present
//     wr_ready     out 1            write can be accepted (state decode only)
//     wr_addr      in  ADDR_W       target register
//     wr_data      in  DATA_W       write data
//     clr_start    in  1            start bulk clear (ignored while clearing)
//     clr_busy     out 1            bulk clear in progress
//     wr_done      out 1            registered pulse for a committed write
//     wr_en_onehot out NREG         registered enable of that write
//     regs_flat    out NREG*DATA_W  register k at [k*DATA_W +: DATA_W]
module reg_write_bank #(
  parameter int DATA_W = reg_write_bank_pkg::DATA_W,
  parameter int ADDR_W = reg_write_bank_pkg::ADDR_W,
  parameter int NREG   = reg_write_bank_pkg::NREG
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   wr_done,
  output logic [NREG-1:0]        wr_en_onehot,
  output logic [NREG*DATA_W-1:0] regs_flat
);
  import reg_write_bank_pkg::*;

  localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(NREG - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic [NREG-1:0]   wen;
  logic [DATA_W-1:0] regs [NREG];

  // Handshake outputs come straight from the state register, so there is no
  // combinational path from any input to wr_ready.
  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign accept   = wr_valid & wr_ready;

  decoder_5_32 #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_dec (
    .en     (accept),
    .addr   (wr_addr),
    .onehot (wen)
  );

  // Clear sequencer and write-completion flags. The counter starts at 1 so
  // register 0 is never visited, and it leaves CLEAR on the edge that clears
  // the last register, so it never wraps while clearing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= CNT_FIRST;
      wr_done      <= 1'b0;
      wr_en_onehot <= '0;
    end else begin
      wr_done      <= accept;
      wr_en_onehot <= wen;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= CNT_FIRST;
          end
        end
        CLEAR: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= CNT_FIRST;
          end else begin
            cnt <= cnt + CNT_FIRST;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= CNT_FIRST;
        end
      endcase
    end
  end

  // Register storage. Writes only happen in IDLE and clears only in CLEAR,
  // so the two never target a register on the same edge; a write issued
  // together with clr_start lands first and is zeroed later by the sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      regs[0] <= '0;
      for (int k = 1; k < NREG; k++) begin
        if (wen[k])
          regs[k] <= wr_data;
        else if (state == CLEAR && cnt == ADDR_W'(k))
          regs[k] <= '0;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NREG; k++) regs_flat[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: tb/tb_reg_write_bank.sv
module tb_reg_write_bank;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              clr_start;
  logic              clr_busy;
  logic              wr_done;
  logic [NR-1:0]     wr_en_onehot;
  logic [NR*DW-1:0]  regs_flat;

  always #5 clock = ~clock;

  reg_write_bank dut (
    .clock        (clock),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .wr_done      (wr_done),
    .wr_en_onehot (wr_en_onehot),
    .regs_flat    (regs_flat)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] mreg [NR];
  int          edge_n   = 0;
  int          clr_edge = -1;   // edge at which the running clear was started
  bit          exp_done = 1'b0;
  bit          started  = 1'b0;
  int          n_cmp    = 0;
  int          n_bad    = 0;
  logic        rdy_s, busy_s;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Reference model: register k is zeroed by the k-th edge after the clear
  // start; writes commit whenever no clear is running.
  always @(posedge clock) begin : model
    bit busy;
    int k;
    edge_n++;
    if (reset) begin
      for (int i = 0; i < NR; i++) mreg[i] = '0;
      clr_edge = -1;
      exp_done = 1'b0;
      sb.delete();
      started  = 1'b1;
    end else if (started) begin
      busy     = (clr_edge >= 0);
      exp_done = 1'b0;
      if (wr_valid && !busy) begin
        mreg[wr_addr] = (wr_addr == 0) ? 32'h0 : wr_data;
        sb.push_back('{int'(wr_addr), wr_data});
        exp_done = 1'b1;
      end
      if (busy) begin
        k = edge_n - clr_edge;
        mreg[k] = '0;
        if (k >= NR - 1) clr_edge = -1;
      end else if (clr_start) begin
        clr_edge = edge_n;
      end
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clock) begin : monitor
    int  bad_slot;
    wr_t e;
    if (started) begin
      check("wr_ready", 64'(wr_ready), 64'(clr_edge < 0));
      check("clr_busy", 64'(clr_busy), 64'(clr_edge >= 0));
      check("wr_done", 64'(wr_done), 64'(exp_done));
      bad_slot = -1;
      for (int k = 0; k < NR; k++)
        if (regs_flat[k*DW +: DW] !== mreg[k] && bad_slot < 0) bad_slot = k;
      n_cmp++;
      if (bad_slot >= 0) begin
        n_bad++;
        $display("FAIL regs slot %0d: got %h expected %h (edge %0d)", bad_slot,
                 regs_flat[bad_slot*DW +: DW], mreg[bad_slot], edge_n);
      end
      if (wr_done === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("onehot", 64'(wr_en_onehot), 64'(32'h1 << e.addr));
          check("wdata", 64'(regs_flat[e.addr*DW +: DW]), 64'((e.addr == 0) ? 32'h0 : e.data));
        end
      end else begin
        check("onehot_idle", 64'(wr_en_onehot), 64'(0));
      end
    end
  end

  task automatic step();
    @(negedge clock);
    rdy_s  = wr_ready;
    busy_s = clr_busy;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, output int waits);
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    waits    = 0;
    do begin
      step();
      waits++;
    end while (!rdy_s && waits < 100);
    if (!rdy_s) check("wr_timeout", 64'(0), 64'(1));
    wr_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int w;
    int n;
    reset = 1'b1; wr_valid = 1'b0; clr_start = 1'b0; wr_addr = '0; wr_data = '0;
    step(); step();
    reset = 1'b0;

    wr(5, 32'hDEADBEEF, w);
    check("t_slot5", 64'(regs_flat[5*DW +: DW]), 64'(32'hDEADBEEF));
    check("t_done5", 64'(wr_done), 64'(1));
    check("t_oh5", 64'(wr_en_onehot), 64'(32'h00000020));

    wr(0, 32'hFFFFFFFF, w);
    check("t_slot0", 64'(regs_flat[0 +: DW]), 64'(0));
    check("t_oh0", 64'(wr_en_onehot), 64'(32'h1));

    for (int i = 1; i < NR; i++) wr(i, 32'(i * 3), w);
    clr_start = 1'b1; step(); clr_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy_s) n++;
      else break;
    end
    check("clr_len", 64'(n), 64'(31));

    clr_start = 1'b1; step(); clr_start = 1'b0;
    step(); step(); step();
    wr(7, 32'h12345678, w);
    check("clr_write_wait", 64'(w), 64'(29));
    check("t_slot7", 64'(regs_flat[7*DW +: DW]), 64'(32'h12345678));

    wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5; clr_start = 1'b1;
    step();
    wr_valid = 1'b0; clr_start = 1'b0;
    check("t_slot31_w", 64'(regs_flat[31*DW +: DW]), 64'(32'hA5A5A5A5));
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy_s) break;
    end
    check("t_slot31_c", 64'(regs_flat[31*DW +: DW]), 64'(0));

    for (int i = 1; i < NR; i++) wr(i, $urandom, w);
    clr_start = 1'b1; step(); clr_start = 1'b0;
    repeat (9) step();
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_ready", 64'(wr_ready), 64'(1));
    check("rst_busy", 64'(clr_busy), 64'(0));
    check("rst_regs_zero", 64'(regs_flat != '0), 64'(0));
    wr(3, 32'hCAFE0003, w);
    check("t_slot3", 64'(regs_flat[3*DW +: DW]), 64'(32'hCAFE0003));

    rdy_s = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(wr_valid && !rdy_s)) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_addr  = AW'($urandom);
        wr_data  = $urandom;
      end
      clr_start = ($urandom_range(0, 49) == 0);
      step();
    end
    wr_valid = 1'b0; clr_start = 1'b0;
    step(); step(); step();
    check("sb_drain", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
